xor_operand_loader: RTL and testbench

//   Upstream feeder for the 8-input parameterised XOR reducer. Accepts a serial

---
 rtl/xor_operand_loader_if.sv | 39 +++
 rtl/xor_operand_loader.sv | 122 ++++++++++++
 tb/tb_xor_operand_loader.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/xor_operand_loader_if.sv
// Purpose : Handshake and operand bus between a word producer, the
//           xor_operand_loader and the downstream XOR reducer.
// Signals : in_data/in_valid/in_last/in_ready  serial word input with handshake
//           out_a..out_h                        parallel operand slots 0..7
//           out_count                           words loaded in the held group
//           out_valid/out_ready                 group handoff handshake
// Modports: master - producer/consumer side (drives words, takes groups)
//           slave  - the loader itself
interface xor_operand_loader_if #(
  parameter int WIDTH = 8
) ();
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic [WIDTH-1:0] out_a;
  logic [WIDTH-1:0] out_b;
  logic [WIDTH-1:0] out_c;
  logic [WIDTH-1:0] out_d;
  logic [WIDTH-1:0] out_e;
  logic [WIDTH-1:0] out_f;
  logic [WIDTH-1:0] out_g;
  logic [WIDTH-1:0] out_h;
  logic [3:0]       out_count;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_a, out_b, out_c, out_d, out_e, out_f, out_g, out_h,
           out_count, out_valid
  );

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_a, out_b, out_c, out_d, out_e, out_f, out_g, out_h,
           out_count, out_valid
  );
endinterface

// File: rtl/xor_operand_loader.sv
// Purpose : Packs a serial stream of WIDTH-bit words into up to PORT_NUM
//           operand slots for an 8-input XOR reducer. A group closes when
//           PORT_NUM words have been taken or a word arrives with in_last.
//           The closed group is held on the slot outputs with out_valid until
//           the consumer asserts out_ready; then the slots are cleared and
//           filling restarts. Slots at index >= PORT_NUM are tied to zero.
// Ports   : clk  - rising-edge clock
//           rst  - synchronous active-high reset
//           bus  - xor_operand_loader_if slave modport (word input handshake,
//                  slot outputs out_a..out_h, out_count, out_valid/out_ready)
module xor_operand_loader #(
  parameter int PORT_NUM = 2,
  parameter int WIDTH    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  xor_operand_loader_if.slave  bus
);

  if (PORT_NUM < 2 || PORT_NUM > 8) begin : g_bad_port_num
    $error("xor_operand_loader: PORT_NUM must lie in 2..8");
  end

  localparam logic [2:0] LAST_IDX = 3'(PORT_NUM - 1);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [2:0] idx;
  logic [2:0] idx_next;
  logic       accept;
  logic       close_grp;
  logic       rel_grp;
  logic [3:0] count;

  logic [7:0][WIDTH-1:0] slots;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FILL;
      idx   <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
    end
  end

  // The handshake decode looks only at the state register, so in_valid never
  // feeds in_ready combinationally; rst forces both low while asserted.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    accept     = 1'b0;
    close_grp  = 1'b0;
    rel_grp    = 1'b0;
    unique case (state)
      FILL: begin
        if (bus.in_valid) begin
          accept = 1'b1;
          if (idx == LAST_IDX || bus.in_last) begin
            close_grp  = 1'b1;
            state_next = HOLD;
            idx_next   = '0;
          end else begin
            idx_next = idx + 3'd1;
          end
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          rel_grp    = 1'b1;
          state_next = FILL;
        end
      end
      default: state_next = FILL;
    endcase
  end

  // Slots beyond PORT_NUM never hold a word, so they are plain zero rather
  // than registers; the used ones are cleared on handoff so an early-closed
  // group leaves its unwritten slots at zero.
  for (genvar k = 0; k < 8; k++) begin : g_slot
    if (k < PORT_NUM) begin : g_used
      logic [WIDTH-1:0] slot_q;
      always_ff @(posedge clk) begin
        if (rst || rel_grp) begin
          slot_q <= '0;
        end else if (accept && idx == 3'(k)) begin
          slot_q <= bus.in_data;
        end
      end
      assign slots[k] = slot_q;
    end else begin : g_unused
      assign slots[k] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || rel_grp) begin
      count <= '0;
    end else if (close_grp) begin
      count <= 4'(idx) + 4'd1;
    end
  end

  assign bus.in_ready  = (state == FILL) && !rst;
  assign bus.out_valid = (state == HOLD) && !rst;
  assign bus.out_count = count;
  assign bus.out_a     = slots[0];
  assign bus.out_b     = slots[1];
  assign bus.out_c     = slots[2];
  assign bus.out_d     = slots[3];
  assign bus.out_e     = slots[4];
  assign bus.out_f     = slots[5];
  assign bus.out_g     = slots[6];
  assign bus.out_h     = slots[7];

endmodule

// File: tb/tb_xor_operand_loader.sv
// Purpose : Testbench for xor_operand_loader. Three loaders (PORT_NUM 2, 4
//           and 8) share one input stimulus; each is tracked by a queue-based
//           group model and compared every cycle, plus directed checks.
module tb_xor_operand_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       out_ready;

  logic [63:0] o_slots [3];
  logic [3:0]  o_cnt   [3];
  logic        o_val   [3];
  logic        o_rdy   [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int N = (g == 0) ? 2 : (g == 1) ? 4 : 8;
    xor_operand_loader_if #(.WIDTH(8)) bus ();
    assign bus.in_data   = in_data;
    assign bus.in_valid  = in_valid;
    assign bus.in_last   = in_last;
    assign bus.out_ready = out_ready;
    xor_operand_loader #(.PORT_NUM(N), .WIDTH(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
    assign o_slots[g] = {bus.out_h, bus.out_g, bus.out_f, bus.out_e,
                         bus.out_d, bus.out_c, bus.out_b, bus.out_a};
    assign o_cnt[g]   = bus.out_count;
    assign o_val[g]   = bus.out_valid;
    assign o_rdy[g]   = bus.in_ready;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: each loader is a list of words collected so far plus a
  // flag saying the list is a finished group waiting for the consumer.
  logic [7:0] grp  [3][$];
  bit         held [3];
  int         groups [3];
  int         np [3] = '{2, 4, 8};

  function automatic logic [63:0] model_slots(input int j);
    logic [63:0] r = '0;
    for (int i = 0; i < grp[j].size(); i++) r[i*8 +: 8] = grp[j][i];
    return r;
  endfunction

  function automatic logic [7:0] xor_bytes(input logic [63:0] v);
    logic [7:0] r = '0;
    for (int i = 0; i < 8; i++) r ^= v[i*8 +: 8];
    return r;
  endfunction

  task automatic check_all();
    for (int j = 0; j < 3; j++) begin
      check($sformatf("in_ready[N=%0d]", np[j]), 64'(o_rdy[j]), 64'(!rst && !held[j]));
      check($sformatf("out_valid[N=%0d]", np[j]), 64'(o_val[j]), 64'(!rst && held[j]));
      check($sformatf("slots[N=%0d]", np[j]), o_slots[j], model_slots(j));
      check($sformatf("out_count[N=%0d]", np[j]), 64'(o_cnt[j]),
            held[j] ? 64'(grp[j].size()) : 64'd0);
      if (held[j])
        check($sformatf("xor[N=%0d]", np[j]), 64'(xor_bytes(o_slots[j])),
              64'(xor_bytes(model_slots(j))));
    end
  endtask

  task automatic model_update();
    for (int j = 0; j < 3; j++) begin
      if (rst) begin
        grp[j].delete();
        held[j] = 1'b0;
      end else if (held[j]) begin
        if (out_ready) begin
          held[j] = 1'b0;
          grp[j].delete();
        end
      end else if (in_valid) begin
        grp[j].push_back(in_data);
        if (grp[j].size() == np[j] || in_last) begin
          held[j] = 1'b1;
          groups[j]++;
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_all();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int cycles;
    int target;
    rst       = 1'b1;
    in_data   = '0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tick();
    rst = 1'b0;

    // Two words into the N=2 loader.
    send(8'h3C, 1'b0);
    send(8'h0F, 1'b0);
    check("t1_valid", 64'(o_val[0]), 64'd1);
    check("t1_slots", o_slots[0], 64'h0000_0000_0000_0F3C);
    check("t1_count", 64'(o_cnt[0]), 64'd2);
    check("t1_xor", 64'(xor_bytes(o_slots[0])), 64'h33);

    // Full eight-word group.
    do_reset();
    for (int i = 0; i < 8; i++) send(8'(1 << i), 1'b0);
    check("t2_valid", 64'(o_val[2]), 64'd1);
    check("t2_slots", o_slots[2], 64'h8040_2010_0804_0201);
    check("t2_count", 64'(o_cnt[2]), 64'd8);
    check("t2_xor", 64'(xor_bytes(o_slots[2])), 64'hFF);

    // Back-pressure on the held group.
    in_valid  = 1'b1;
    in_data   = 8'h77;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t4_ready_low", 64'(o_rdy[2]), 64'd0);
      check("t4_frozen", o_slots[2], 64'h8040_2010_0804_0201);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t4_ready_back", 64'(o_rdy[2]), 64'd1);
    check("t4_cleared", o_slots[2], 64'd0);
    check("t4_valid_low", 64'(o_val[2]), 64'd0);

    // Early close with in_last.
    do_reset();
    send(8'hAA, 1'b0);
    send(8'h55, 1'b1);
    check("t3_slots8", o_slots[2], 64'h0000_0000_0000_55AA);
    check("t3_count8", 64'(o_cnt[2]), 64'd2);
    check("t3_slots4", o_slots[1], 64'h0000_0000_0000_55AA);
    check("t3_count4", 64'(o_cnt[1]), 64'd2);

    // Reset in the middle of a group.
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    do_reset();
    tick();
    check("t5_no_valid", 64'(o_val[1]), 64'd0);
    check("t5_cleared", o_slots[1], 64'd0);
    for (int i = 1; i <= 4; i++) send(8'(8'hA0 + i), 1'b0);
    check("t5_valid", 64'(o_val[1]), 64'd1);
    check("t5_count", 64'(o_cnt[1]), 64'd4);
    check("t5_slots", o_slots[1], 64'h0000_0000_A4A3_A2A1);

    // Random traffic with gaps on both sides.
    do_reset();
    target = groups[2] + 1000;
    cycles = 0;
    while (groups[2] < target && cycles < 60000) begin
      in_valid  = ($urandom % 4) != 0;
      in_last   = ($urandom % 8) == 0;
      in_data   = 8'($urandom);
      out_ready = ($urandom % 3) == 0;
      tick();
      cycles++;
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    check("random_groups_done", 64'(groups[2] >= target), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
